// File: rtl/cpu_pkg.sv
// Shared control-unit definitions: opcode encoding, register commands and
// the program sequencer state encoding.
package cpu_pkg;

    localparam logic [2:0] OP_HALT    = 3'b000;
    localparam logic [2:0] OP_CLDRD   = 3'b001;
    localparam logic [2:0] OP_ADDLD   = 3'b010;
    localparam logic [2:0] OP_ADD     = 3'b011;
    localparam logic [2:0] OP_DIV2    = 3'b100;
    localparam logic [2:0] OP_DISPLAY = 3'b101;

    // Register commands driven by the control unit onto Tx/Ty/Tz/tula
    localparam logic [2:0] HOLD   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] SHIFTR = 3'd2;
    localparam logic [2:0] SHIFTL = 3'd3;
    localparam logic [2:0] RESET  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program word store: synchronous write, combinational read, no reset so the
// loaded program survives a sequencer reset.
module prog_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [2:0]        wopcode,
    input  logic [DATA_W-1:0] woperand,
    input  logic [AW-1:0]     raddr,
    output logic [2:0]        ropcode,
    output logic [DATA_W-1:0] roperand
);

    logic [2:0]        op_mem  [DEPTH];
    logic [DATA_W-1:0] opd_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            op_mem[waddr]  <= wopcode;
            opd_mem[waddr] <= woperand;
        end
    end

    assign ropcode  = op_mem[raddr];
    assign roperand = opd_mem[raddr];

endmodule

// File: rtl/program_sequencer.sv
// Issues one stored instruction per clock to the control unit from address 0
// until a HALT word or the last address; stall inserts a 000 bubble.
module program_sequencer
    import cpu_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int DATA_W     = 4,
    localparam int AW        = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [2:0]        prog_opcode,
    input  logic [DATA_W-1:0] prog_operand,
    input  logic              start,
    input  logic              stall,
    output logic [2:0]        opcode,
    output logic [DATA_W-1:0] operand,
    output logic [AW-1:0]     pc,
    output logic              busy,
    output logic              done,
    output logic [AW:0]       issued_cnt
);

    seq_state_t        state, state_next;
    logic [AW-1:0]     pc_next;
    logic [2:0]        opcode_next;
    logic [DATA_W-1:0] operand_next;
    logic [AW:0]       cnt_next;
    logic              mem_we;
    logic [2:0]        rd_opcode;
    logic [DATA_W-1:0] rd_operand;

    prog_mem #(
        .DEPTH  (PROG_DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk      (clk),
        .we       (mem_we),
        .waddr    (prog_addr),
        .wopcode  (prog_opcode),
        .woperand (prog_operand),
        .raddr    (pc),
        .ropcode  (rd_opcode),
        .roperand (rd_operand)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Opcode/operand default to 000/0 so the bus is clean between issues
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        opcode_next  = OP_HALT;
        operand_next = '0;
        cnt_next     = issued_cnt;
        mem_we       = 1'b0;
        case (state)
            IDLE: begin
                mem_we = prog_we;
                if (start) begin
                    state_next = RUN;
                    pc_next    = '0;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (rd_opcode == OP_HALT) begin
                        state_next = DONE;
                    end else begin
                        opcode_next  = rd_opcode;
                        operand_next = rd_operand;
                        cnt_next     = issued_cnt + (AW+1)'(1);
                        if (&pc) begin
                            pc_next    = '0;
                            state_next = DONE;
                        end else begin
                            pc_next = pc + AW'(1);
                        end
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= '0;
            opcode     <= OP_HALT;
            operand    <= '0;
            issued_cnt <= '0;
        end else begin
            pc         <= pc_next;
            opcode     <= opcode_next;
            operand    <= operand_next;
            issued_cnt <= cnt_next;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_program_sequencer.sv
// Randomized bench for program_sequencer against an array-based program model.
module tb_program_sequencer;

    localparam int DEPTH = 16;
    localparam int DW    = 4;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [2:0]    prog_opcode;
    logic [DW-1:0] prog_operand;
    logic          start;
    logic          stall;
    logic [2:0]    opcode;
    logic [DW-1:0] operand;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [AW:0]   issued_cnt;

    program_sequencer #(.PROG_DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_opcode  (prog_opcode),
        .prog_operand (prog_operand),
        .start        (start),
        .stall        (stall),
        .opcode       (opcode),
        .operand      (operand),
        .pc           (pc),
        .busy         (busy),
        .done         (done),
        .issued_cnt   (issued_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference program contents as the sequencer should see them
    logic [2:0]    m_op   [DEPTH];
    logic [DW-1:0] m_opnd [DEPTH];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic write_word(input int a, input logic [2:0] op, input logic [DW-1:0] opnd);
        @(negedge clk);
        prog_we      = 1'b1;
        prog_addr    = AW'(a);
        prog_opcode  = op;
        prog_operand = opnd;
        m_op[a]      = op;
        m_opnd[a]    = opnd;
        @(posedge clk);
        #1 prog_we = 1'b0;
    endtask

    // Start a run and follow it: each non-stalled RUN cycle consumes the next
    // program word; a HALT word or the last address ends the run.
    task automatic run_program(input bit rand_stall, input logic [63:0] sched, input bit noise,
                               input bit wr0, input logic [2:0] w_op, input logic [DW-1:0] w_opnd);
        int idx = 0;
        int cnt = 0;
        bit fin = 1'b0;
        bit s;
        @(negedge clk);
        start = 1'b1;
        if (wr0) begin
            prog_we      = 1'b1;
            prog_addr    = '0;
            prog_opcode  = w_op;
            prog_operand = w_opnd;
            m_op[0]      = w_op;
            m_opnd[0]    = w_opnd;
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        prog_we = 1'b0;
        chk("run_busy", busy, 1);
        chk("run_pc0", pc, 0);
        chk("run_cnt0", issued_cnt, 0);
        chk("run_op_first", opcode, 0);
        for (int c = 0; c < 4*DEPTH+8 && !fin; c++) begin
            @(negedge clk);
            s = rand_stall ? ($urandom_range(0, 2) == 0) : sched[c];
            stall = s;
            if (noise) begin
                prog_we      = 1'($urandom_range(0, 1));
                prog_addr    = AW'($urandom);
                prog_opcode  = 3'($urandom);
                prog_operand = DW'($urandom);
                start        = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            if (s) begin
                chk("stall_op", opcode, 0);
                chk("stall_opnd", operand, 0);
                chk("stall_pc", pc, idx);
                chk("stall_cnt", issued_cnt, cnt);
                chk("stall_busy", busy, 1);
            end else if (m_op[idx] == 3'b000) begin
                chk("halt_op", opcode, 0);
                chk("halt_done", done, 1);
                chk("halt_busy", busy, 0);
                chk("halt_cnt", issued_cnt, cnt);
                fin = 1'b1;
            end else begin
                chk("issue_op", opcode, m_op[idx]);
                chk("issue_opnd", operand, m_opnd[idx]);
                cnt++;
                chk("issue_cnt", issued_cnt, cnt);
                if (idx == DEPTH-1) begin
                    chk("last_pc", pc, 0);
                    chk("last_done", done, 1);
                    fin = 1'b1;
                end else begin
                    idx++;
                    chk("issue_pc", pc, idx);
                    chk("issue_busy", busy, 1);
                    chk("issue_nodone", done, 0);
                end
            end
        end
        chk("run_finished", fin, 1);
        // Start and write attempts in the done cycle must not take effect
        @(negedge clk);
        stall        = 1'b0;
        start        = 1'b1;
        prog_we      = noise;
        prog_addr    = AW'(1);
        prog_opcode  = 3'($urandom);
        prog_operand = DW'($urandom);
        @(posedge clk);
        #1;
        start   = 1'b0;
        prog_we = 1'b0;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_op", opcode, 0);
        chk("final_cnt", issued_cnt, cnt);
        @(posedge clk);
        #1;
        chk("idle_stay", busy, 0);
        chk("idle_cnt_hold", issued_cnt, cnt);
    endtask

    // Abort a run with rst once pc reaches 2; needs words 0 and 1 non-HALT
    task automatic abort_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_pre_pc", pc, 2);
        chk("abort_pre_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_op", opcode, 0);
        chk("abort_opnd", operand, 0);
        chk("abort_pc", pc, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_cnt", issued_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
        end
    endtask

    initial begin
        rst          = 1'b0;
        prog_we      = 1'b0;
        prog_addr    = '0;
        prog_opcode  = '0;
        prog_operand = '0;
        start        = 1'b0;
        stall        = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_op", opcode, 0);
        chk("rst_opnd", operand, 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", issued_cnt, 0);

        write_word(0, 3'b001, 4'd3);
        write_word(1, 3'b010, 4'd5);
        write_word(2, 3'b011, 4'd0);
        write_word(3, 3'b101, 4'd0);
        write_word(4, 3'b000, 4'd0);
        run_program(1'b0, 64'd0, 1'b0, 1'b0, 3'b0, 4'd0);
        run_program(1'b0, 64'b1100, 1'b0, 1'b0, 3'b0, 4'd0);
        abort_run();
        run_program(1'b0, 64'd0, 1'b1, 1'b0, 3'b0, 4'd0);

        for (int a = 0; a < DEPTH; a++) write_word(a, 3'b100, DW'(a));
        run_program(1'b0, 64'd0, 1'b0, 1'b0, 3'b0, 4'd0);
        run_program(1'b0, 64'd0, 1'b0, 1'b1, 3'b010, 4'd9);

        for (int t = 0; t < 8; t++) begin
            int halt_at;
            halt_at = $urandom_range(0, DEPTH + 3);
            for (int a = 0; a < DEPTH; a++)
                write_word(a, (a == halt_at) ? 3'b000 : 3'($urandom_range(1, 7)), DW'($urandom));
            run_program(1'b1, 64'd0, 1'b1, 1'b0, 3'b0, 4'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
